// File: rtl/widen_pack.sv
// rtl/widen_pack.sv - narrow-to-wide packer, first token in the LSB slice, registered output.
module widen_pack #(
  parameter int INPUT_TYPE  = 8,
  parameter int OUTPUT_TYPE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_TYPE-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic [OUTPUT_TYPE-1:0] outs,
  output logic                   outs_valid,
  input  logic                   outs_ready
);

  localparam int RATIO = OUTPUT_TYPE / INPUT_TYPE;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic                   last;
  logic [OUTPUT_TYPE-1:0] wide;
  logic                   in_xfer;
  logic                   out_xfer;
  logic [OUTPUT_TYPE-1:0] outs_q, outs_d;
  logic                   full_q, full_d;

  // Only the last slice competes for the output register; earlier slices go to staging.
  assign ins_ready  = ~last | ~full_q | outs_ready;
  assign in_xfer    = ins_valid & ins_ready;
  assign out_xfer   = full_q & outs_ready;
  assign outs       = outs_q;
  assign outs_valid = full_q;

  generate
    if (RATIO > 1) begin : g_stage
      localparam int SW = (RATIO - 1) * INPUT_TYPE;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [SW-1:0] stg_q, stg_d;

      assign last = (cnt_q == CW'(RATIO - 1));
      assign wide = {ins, stg_q};

      always_comb begin
        cnt_d = cnt_q;
        stg_d = stg_q;
        if (in_xfer) begin
          if (last) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            for (int i = 0; i < RATIO - 1; i++) begin
              if (cnt_q == CW'(i)) stg_d[i*INPUT_TYPE +: INPUT_TYPE] = ins;
            end
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
          stg_q <= '0;
        end else begin
          cnt_q <= cnt_d;
          stg_q <= stg_d;
        end
      end
    end else begin : g_pass
      // Zero-width staging: every token is a last slice.
      assign last = 1'b1;
      assign wide = ins;
    end
  endgenerate

  always_comb begin
    outs_d = outs_q;
    full_d = full_q;
    if (in_xfer && last) begin
      outs_d = wide;
      full_d = 1'b1;
    end else if (out_xfer) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outs_q <= '0;
      full_q <= 1'b0;
    end else begin
      outs_q <= outs_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_widen_pack.sv
// tb/tb_widen_pack.sv - bench for widen_pack at 8->32 and 16->16.
module tb_widen_pack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  ins;
  logic        ins_valid, ins_ready;
  logic [31:0] outs;
  logic        outs_valid, outs_ready;

  logic [15:0] ins1;
  logic        ins1_valid, ins1_ready;
  logic [15:0] outs1;
  logic        outs1_valid, outs1_ready;

  int total = 0;
  int bad   = 0;

  widen_pack #(.INPUT_TYPE(8), .OUTPUT_TYPE(32)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
  );

  widen_pack #(.INPUT_TYPE(16), .OUTPUT_TYPE(16)) dut1 (
    .clk(clk), .rst(rst), .ins(ins1), .ins_valid(ins1_valid), .ins_ready(ins1_ready),
    .outs(outs1), .outs_valid(outs1_valid), .outs_ready(outs1_ready)
  );

  task automatic do_reset();
    rst = 1'b1;
    ins_valid = 1'b0; ins = '0; outs_ready = 1'b0;
    ins1_valid = 1'b0; ins1 = '0; outs1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Drive one cycle; rdy is ins_ready as seen just before the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit ordy, output bit rdy);
    ins_valid = v; ins = d; outs_ready = ordy;
    #1;
    rdy = ins_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ins_valid = 1'b0; ins = '0; outs_ready = 1'b0;
    ins1_valid = 1'b0; ins1 = '0; outs1_ready = 1'b0;
    @(posedge clk); #2;
    total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", outs_valid); end
    total++; if (outs !== 32'h0) begin bad++; $display("FAIL reset_outs got=%h exp=0", outs); end
    total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ins_ready); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", ins_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bit r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[i], 1'b1, r);
      total++; if (r !== 1'b1) begin bad++; $display("FAIL basic_ready i=%0d got=%b exp=1", i, r); end
      if (i < 3) begin
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL basic_early i=%0d got=%b exp=0", i, outs_valid); end
      end
    end
    total++; if (outs_valid !== 1'b1 || outs !== 32'h44332211) begin
      bad++; $display("FAIL basic_word got=%b/%h exp=1/44332211", outs_valid, outs);
    end
    step(1'b0, 8'h00, 1'b1, r);
    total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL basic_oneshot got=%b exp=0", outs_valid); end
  endtask

  task automatic test_stream();
    bit r;
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(i), 1'b1, r);
      total++; if (r !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, r); end
      if (i % 4 == 3) begin
        exp = 0;
        for (int k = 0; k < 4; k++) exp = exp + (32'(i - 3 + k) << (8 * k));
        total++; if (outs_valid !== 1'b1 || outs !== exp) begin
          bad++; $display("FAIL stream_word i=%0d got=%b/%h exp=1/%h", i, outs_valid, outs, exp);
        end
      end else begin
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL stream_gap i=%0d got=%b exp=0", i, outs_valid); end
      end
    end
    step(1'b0, 8'h00, 1'b1, r);
  endtask

  task automatic test_backpressure();
    bit r;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b1, r);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hA0 + 8'(i), 1'b0, r);
      total++; if (r !== 1'b1) begin bad++; $display("FAIL bp_accept i=%0d got=%b exp=1", i, r); end
      total++; if (outs_valid !== 1'b1 || outs !== 32'h03020100) begin
        bad++; $display("FAIL bp_hold i=%0d got=%b/%h exp=1/03020100", i, outs_valid, outs);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'hA3, 1'b0, r);
      total++; if (r !== 1'b0) begin bad++; $display("FAIL bp_stall i=%0d got=%b exp=0", i, r); end
      total++; if (outs_valid !== 1'b1 || outs !== 32'h03020100) begin
        bad++; $display("FAIL bp_stable i=%0d got=%b/%h exp=1/03020100", i, outs_valid, outs);
      end
    end
    step(1'b1, 8'hA3, 1'b1, r);
    total++; if (r !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", r); end
    total++; if (outs_valid !== 1'b1 || outs !== 32'hA3A2A1A0) begin
      bad++; $display("FAIL bp_swap got=%b/%h exp=1/a3a2a1a0", outs_valid, outs);
    end
    step(1'b0, 8'h00, 1'b1, r);
    total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", outs_valid); end
  endtask

  task automatic test_gaps();
    bit         vs [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] ds [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03, 8'h00, 8'h04};
    bit r;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vs[i], ds[i], 1'b1, r);
      if (i < 7) begin
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL gaps_early i=%0d got=%b exp=0", i, outs_valid); end
      end
    end
    total++; if (outs_valid !== 1'b1 || outs !== 32'h04030201) begin
      bad++; $display("FAIL gaps_word got=%b/%h exp=1/04030201", outs_valid, outs);
    end
    step(1'b0, 8'h00, 1'b1, r);
  endtask

  task automatic test_reset_mid();
    bit r;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'h10 * 8'(i + 1), 1'b0, r);
    step(1'b1, 8'h55, 1'b0, r);
    step(1'b1, 8'h66, 1'b0, r);
    ins_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (outs_valid !== 1'b0 || outs !== 32'h0) begin
      bad++; $display("FAIL rstmid_async got=%b/%h exp=0/0", outs_valid, outs);
    end
    total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ins_ready); end
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(i + 1), 1'b1, r);
      if (i < 3) begin
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early i=%0d got=%b exp=0", i, outs_valid); end
      end
    end
    total++; if (outs_valid !== 1'b1 || outs !== 32'h04030201) begin
      bad++; $display("FAIL rstmid_word got=%b/%h exp=1/04030201", outs_valid, outs);
    end
    step(1'b0, 8'h00, 1'b1, r);
  endtask

  task automatic test_ratio1();
    do_reset();
    ins1 = 16'hBEEF; ins1_valid = 1'b1; outs1_ready = 1'b0;
    #1;
    total++; if (ins1_ready !== 1'b1) begin bad++; $display("FAIL r1_ready0 got=%b exp=1", ins1_ready); end
    @(posedge clk); #1;
    total++; if (outs1_valid !== 1'b1 || outs1 !== 16'hBEEF) begin
      bad++; $display("FAIL r1_first got=%b/%h exp=1/beef", outs1_valid, outs1);
    end
    ins1 = 16'hCAFE;
    #1;
    total++; if (ins1_ready !== 1'b0) begin bad++; $display("FAIL r1_stall got=%b exp=0", ins1_ready); end
    @(posedge clk); #1;
    total++; if (outs1_valid !== 1'b1 || outs1 !== 16'hBEEF) begin
      bad++; $display("FAIL r1_hold got=%b/%h exp=1/beef", outs1_valid, outs1);
    end
    outs1_ready = 1'b1;
    #1;
    total++; if (ins1_ready !== 1'b1) begin bad++; $display("FAIL r1_release got=%b exp=1", ins1_ready); end
    @(posedge clk); #1;
    total++; if (outs1_valid !== 1'b1 || outs1 !== 16'hCAFE) begin
      bad++; $display("FAIL r1_second got=%b/%h exp=1/cafe", outs1_valid, outs1);
    end
    ins1_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (outs1_valid !== 1'b0) begin bad++; $display("FAIL r1_drain got=%b exp=0", outs1_valid); end
    outs1_ready = 1'b0;
  endtask

  // Reference: a list of bytes collected so far and at most one pending packed word.
  task automatic test_random();
    logic [7:0]  pend [$];
    bit          mfull;
    logic [31:0] mword;
    bit v, o, exp_rdy, in_hs, out_hs, loaded;
    logic [7:0] d;
    int words;
    do_reset();
    mfull = 1'b0; mword = '0; words = 0;
    for (int c = 0; c < 500; c++) begin
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 1) != 0);
      d = 8'($urandom);
      ins_valid = v; ins = d; outs_ready = o;
      #1;
      exp_rdy = (pend.size() != 3) || !mfull || o;
      total++; if (ins_ready !== exp_rdy) begin
        bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, ins_ready, exp_rdy);
      end
      in_hs  = v && exp_rdy;
      out_hs = mfull && o;
      @(posedge clk); #1;
      loaded = 1'b0;
      if (in_hs) begin
        pend.push_back(d);
        if (pend.size() == 4) begin
          mword = 0;
          for (int k = 0; k < 4; k++) mword = mword + (32'(pend[k]) << (8 * k));
          pend.delete();
          mfull = 1'b1;
          loaded = 1'b1;
          words++;
        end
      end
      if (out_hs && !loaded) mfull = 1'b0;
      total++; if (outs_valid !== mfull) begin
        bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, outs_valid, mfull);
      end
      if (mfull) begin
        total++; if (outs !== mword) begin
          bad++; $display("FAIL rand_word c=%0d got=%h exp=%h", c, outs, mword);
        end
      end
    end
    total++; if (words < 20) begin bad++; $display("FAIL rand_coverage words=%0d exp>=20", words); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_ratio1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/widen_pack.md
# widen_pack

Narrow-to-wide packing stage for the dataflow handshake fabric: collects RATIO = OUTPUT_TYPE / INPUT_TYPE consecutive narrow tokens and emits one wide token, first-received token in the least-significant slice. It is the inverse of the truncation path. Narrow streams, such as byte-wise memory or channel data, are reassembled into full-width operands before an arithmetic unit. Uses the standard valid/ready handshake on both sides and has a registered output, so it also cuts the combinational path between producer and consumer.

## Interface
Parameters:
- INPUT_TYPE, default 8: width of each narrow input token.
- OUTPUT_TYPE, default 32: width of the packed output token. Must be an integer multiple of INPUT_TYPE. RATIO = OUTPUT_TYPE / INPUT_TYPE ≥ 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- ins  input  INPUT_TYPE  narrow data token.
- ins_valid  input  1  ins carries a valid token.
- ins_ready  output  1  block accepts ins this cycle.
- outs  output  OUTPUT_TYPE  packed wide token.
- outs_valid  output  1  outs holds a valid packed token.
- outs_ready  input  1  consumer accepts outs this cycle.

## Operation
- State:
  - slice counter cnt in 0..RATIO-1.
  - staging register stg of (RATIO-1)*INPUT_TYPE bits.
  - output register outs with full flag out_full, which drives outs_valid.
- Transfer rules:
  - Input transfer: ins_valid & ins_ready.
  - Output transfer: outs_valid & outs_ready.
- Non-last slice (cnt < RATIO-1):
  - ins_ready = 1 unconditionally. The staging register is independent of the output register.
  - On input transfer: stg slice [cnt] ← ins, then cnt ← cnt+1.
- Last slice (cnt = RATIO-1):
  - ins_ready = ~out_full | outs_ready.
  - On input transfer: outs ← {ins, stg}, so ins lands in the top slice; out_full ← 1; cnt ← 0.
- Output drain: on output transfer with no simultaneous last-slice input transfer, out_full ← 0. outs keeps its last value.
- Simultaneous drain and last-slice load: the new word replaces the old one and outs_valid stays 1. No bubble is inserted.
- ins_valid low: state holds. There is no timeout and no flush; a partial word waits indefinitely.
- RATIO = 1: stg has zero width and cnt is constantly 0.
  - Every token is a last slice, so the block degenerates to a one-slot registered buffer with outs = ins.
  - Implementation must guard the zero-width staging register.
- Data on outs is don't-care while outs_valid = 0. Benches must not check it.

## Timing
- Reset (asynchronous assert, synchronous release edge):
  - cnt = 0, stg = 0, outs = 0, outs_valid = 0.
  - ins_ready = 1 during and after reset (cnt = 0 and out_full = 0).
  - A partially collected word is discarded on reset mid-operation.
- Latency: outs_valid rises on the clock edge that accepts the last slice, i.e. it is visible in the cycle after that acceptance.
- Throughput: one narrow token per cycle sustained while outs_ready = 1. One wide token every RATIO cycles.
- Backpressure:
  - With out_full = 1 and outs_ready = 0, the block still accepts slices 0..RATIO-2.
  - It then stalls with ins_ready = 0 at cnt = RATIO-1 until outs_ready = 1.
- Combinational paths:
  - ins_ready depends only on outs_ready plus state.
  - outs and outs_valid are purely registered.
  - There is no valid→ready path on the input side.
- outs and outs_valid must remain stable while outs_valid = 1 and outs_ready = 0.

## Test plan
All scenarios use INPUT_TYPE = 8 and OUTPUT_TYPE = 32 unless noted.
- Basic pack: feed 0x11, 0x22, 0x33, 0x44 on consecutive cycles with outs_ready = 1 → outs = 0x44332211 with outs_valid = 1 exactly one cycle after the 0x44 handshake, for one cycle only.
- Streaming: feed 0x00..0x0B back-to-back with outs_ready = 1 → three words 0x03020100, 0x07060504, 0x0B0A0908. ins_ready never drops.
- Backpressure:
  - Stimulus: hold outs_ready = 0 after the first word completes, then feed 0xA0..0xA3.
  - Required response: 0xA0..0xA2 are accepted and ins_ready = 0 while 0xA3 is presented. Word 0x03020100 stays stable.
  - Then raise outs_ready for one cycle: 0xA3 is accepted in that same cycle and the next outs = 0xA3A2A1A0, with outs_valid continuously high.
- Gaps: feed 0x01, idle 3 cycles, 0x02, 0x03, idle, 0x04 → outs = 0x04030201. No output before the fourth token.
- Reset mid-word: feed 0x55, 0x66, assert rst asynchronously between clock edges → outs_valid = 0 and outs = 0 immediately. After release, 0x01..0x04 → 0x04030201, with no 0x55 or 0x66 leakage.
- RATIO = 1 (INPUT_TYPE = OUTPUT_TYPE = 16):
  - Feed 0xBEEF with outs_ready = 0 → outs = 0xBEEF one cycle later and ins_ready = 0.
  - A second token 0xCAFE is accepted only in the cycle outs_ready = 1, and appears as outs = 0xCAFE the next cycle.
